a51_keystream_ctrl: RTL and testbench

Sequencer and combiner placed directly downstream of the three A5/1 LFSR stages. It drives the key and frame load phase and the 100-cycle warm-up. During run cycles it computes the majority vote from the three sync taps and XORs the three exposed bits into keystream. It packs the 228 keystream bits into two 114-bit burst words, A (downlink) then B (uplink), and hands them to the burst cipher stage over a valid/ready handshake.

---
 rtl/a51_keystream_ctrl_if.sv | 26 ++
 rtl/a51_keystream_ctrl.sv | 169 ++++++++++++++++
 tb/tb_a51_keystream_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a51_keystream_ctrl_if.sv
// Burst-word output channel of the A5/1 keystream controller: one BURSTLEN-bit
// word per transfer, with out_sel marking word A (0) or word B (1).
interface a51_keystream_ctrl_if #(
   parameter int BURSTLEN = 114
) ();

   logic [BURSTLEN-1:0] out_data;
   logic                out_valid;
   logic                out_sel;
   logic                out_ready;

   modport master (
      output out_data,
      output out_valid,
      output out_sel,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_sel,
      output out_ready
   );

endinterface

// File: rtl/a51_keystream_ctrl.sv
// A5/1 sequencer/combiner: load phase, warm-up, majority vote, keystream packing into burst words A and B.
// Optional macro KS_FRAME_AUTOINC_EN: after done, bump the frame number and restart LOAD automatically.
module a51_keystream_ctrl #(
   parameter int KEYLEN      = 64,
   parameter int FRAMENUMLEN = 22,
   parameter int WARMUP      = 100,
   parameter int BURSTLEN    = 114
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [KEYLEN-1:0]             key_i,
   input  logic [FRAMENUMLEN-1:0]        frame_i,
   output logic [KEYLEN+FRAMENUMLEN-1:0] seq_o,
   output logic                          load_o,
   output logic                          run_o,
   output logic                          majority_o,
   input  logic                          sync1_i,
   input  logic                          sync2_i,
   input  logic                          sync3_i,
   input  logic                          exposed1_i,
   input  logic                          exposed2_i,
   input  logic                          exposed3_i,
   a51_keystream_ctrl_if.master          outBus,
   output logic                          busy,
   output logic                          done
);

   localparam int SEQLEN = KEYLEN + FRAMENUMLEN;
   localparam int LCW    = $clog2(SEQLEN);
   localparam int WCW    = $clog2(WARMUP);
   localparam int BCW    = $clog2(BURSTLEN);

   localparam logic [LCW-1:0] LOADLAST = LCW'(SEQLEN - 1);
   localparam logic [WCW-1:0] WARMLAST = WCW'(WARMUP - 1);
   localparam logic [BCW-1:0] BITLAST  = BCW'(BURSTLEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WARM,
      GEN_A,
      GEN_B,
      DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [SEQLEN-1:0]   r_seq;
   logic [LCW-1:0]      r_loadCnt;
   logic [WCW-1:0]      r_warmCnt;
   logic [BCW-1:0]      r_bitCnt;
   logic [BURSTLEN-1:0] r_pack;
   logic                r_packFull;
   logic [BURSTLEN-1:0] r_outData;
   logic                r_outValid;
   logic                r_outSel;
   logic                r_done;

   logic                w_gen;
   logic                w_capture;
   logic                w_lastBit;
   logic                w_accept;
   logic                w_outFree;
   logic                w_transfer;
   logic                w_ksBit;
   logic [BURSTLEN-1:0] w_packNext;

   assign w_gen      = (r_state == GEN_A) || (r_state == GEN_B);
   assign w_capture  = w_gen && !r_packFull;
   assign w_lastBit  = w_capture && (r_bitCnt == BITLAST);
   assign w_accept   = r_outValid && outBus.out_ready;
   assign w_outFree  = !r_outValid || outBus.out_ready;
   assign w_transfer = w_gen && (w_lastBit || r_packFull) && w_outFree;
   assign w_ksBit    = exposed1_i ^ exposed2_i ^ exposed3_i;
   assign w_packNext = {r_pack[BURSTLEN-2:0], w_ksBit};

   // A completed word that cannot hand off freezes the stages until the consumer takes the old one.
   assign load_o     = (r_state == LOAD);
   assign run_o      = (r_state == WARM) || w_capture;
   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign seq_o      = r_seq;
   assign majority_o = (sync1_i & sync2_i) | (sync1_i & sync3_i) | (sync2_i & sync3_i);

   assign outBus.out_data  = r_outData;
   assign outBus.out_valid = r_outValid;
   assign outBus.out_sel   = r_outSel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_nextState = LOAD;
`ifdef KS_FRAME_AUTOINC_EN
            else if (r_done) w_nextState = LOAD;
`endif
         end
         LOAD:    if (r_loadCnt == LOADLAST) w_nextState = WARM;
         WARM:    if (r_warmCnt == WARMLAST) w_nextState = GEN_A;
         GEN_A:   if (w_transfer) w_nextState = GEN_B;
         GEN_B:   if (w_transfer) w_nextState = DRAIN;
         DRAIN:   if (w_accept) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Frame sits in the upper field of the load vector so the auto-increment touches only that slice.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_seq <= '0;
      end else if (r_state == IDLE && start) begin
         r_seq <= {frame_i, key_i};
      end
`ifdef KS_FRAME_AUTOINC_EN
      else if (r_state == IDLE && r_done) begin
         r_seq[SEQLEN-1:KEYLEN] <= r_seq[SEQLEN-1:KEYLEN] + FRAMENUMLEN'(1);
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_loadCnt <= '0;
         r_warmCnt <= '0;
         r_bitCnt  <= '0;
      end else begin
         r_loadCnt <= (r_state == LOAD && r_loadCnt != LOADLAST) ? r_loadCnt + 1'b1 : '0;
         r_warmCnt <= (r_state == WARM && r_warmCnt != WARMLAST) ? r_warmCnt + 1'b1 : '0;
         if (w_capture) r_bitCnt <= w_lastBit ? '0 : r_bitCnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pack     <= '0;
         r_packFull <= 1'b0;
      end else begin
         if (w_capture) r_pack <= w_packNext;
         if (w_transfer)     r_packFull <= 1'b0;
         else if (w_lastBit) r_packFull <= 1'b1;
      end
   end

   // A new word loading on the acceptance edge keeps out_valid high, giving a gapless A-to-B handoff.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_outSel   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (w_transfer) begin
            r_outData  <= r_packFull ? r_pack : w_packNext;
            r_outValid <= 1'b1;
            r_outSel   <= (r_state == GEN_B);
         end else if (w_accept) begin
            r_outValid <= 1'b0;
         end
         r_done <= (r_state == DRAIN) && w_accept;
      end
   end

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Directed bench for a51_keystream_ctrl; a small stand-in LFSR stage feeds the exposed taps.
// Builds with or without KS_FRAME_AUTOINC_EN.
module tb_a51_keystream_ctrl;

   localparam int KEYLEN      = 64;
   localparam int FRAMENUMLEN = 22;
   localparam int BURSTLEN    = 114;
   localparam int SEQLEN      = KEYLEN + FRAMENUMLEN;
   localparam int LOGLEN      = 1024;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   start = 1'b0;
   logic [KEYLEN-1:0]      key_i = '0;
   logic [FRAMENUMLEN-1:0] frame_i = '0;
   logic [SEQLEN-1:0]      seq_o;
   logic                   load_o, run_o, majority_o, busy, done;
   logic                   sync1 = 1'b0, sync2 = 1'b0, sync3 = 1'b0;
   logic                   exposed1, exposed2, exposed3;
   logic                   outReady = 1'b1;
   logic                   patMode = 1'b0;
   logic [15:0]            stageLfsr;

   int checkCount = 0;
   int errorCount = 0;

   logic                loadLog [LOGLEN];
   logic                runLog  [LOGLEN];
   logic                busyLog [LOGLEN];
   logic [BURSTLEN-1:0] dataLog [LOGLEN];
   int                  obsACycle, obsBCycle, obsDoneCycle;
   logic [BURSTLEN-1:0] obsAData, obsBData;
   logic [SEQLEN-1:0]   obsStraySeq;

   a51_keystream_ctrl_if #(.BURSTLEN(BURSTLEN)) outBus ();
   assign outBus.out_ready = outReady;

   a51_keystream_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .key_i      (key_i),
      .frame_i    (frame_i),
      .seq_o      (seq_o),
      .load_o     (load_o),
      .run_o      (run_o),
      .majority_o (majority_o),
      .sync1_i    (sync1),
      .sync2_i    (sync2),
      .sync3_i    (sync3),
      .exposed1_i (exposed1),
      .exposed2_i (exposed2),
      .exposed3_i (exposed3),
      .outBus     (outBus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] lfsrStep(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Stand-in stage: reseeds from the load vector while loading and steps only when run_o allows.
   always_ff @(posedge clock) begin
      if (load_o)     stageLfsr <= seq_o[15:0] ^ 16'hACE1;
      else if (run_o) stageLfsr <= lfsrStep(stageLfsr);
   end

   assign exposed1 = patMode ? 1'b1 : stageLfsr[0];
   assign exposed2 = patMode ? 1'b1 : stageLfsr[5];
   assign exposed3 = patMode ? 1'b1 : stageLfsr[9];

   task automatic modelWords(input logic [15:0] seed, output logic [BURSTLEN-1:0] wa,
                             output logic [BURSTLEN-1:0] wb);
      logic [15:0] s;
      logic        b;
      s = seed;
      wa = '0;
      wb = '0;
      for (int i = 0; i < 100; i++) s = lfsrStep(s);
      for (int i = 0; i < 2 * BURSTLEN; i++) begin
         b = s[0] ^ s[5] ^ s[9];
         if (i < BURSTLEN) wa[BURSTLEN-1-i] = b;
         else              wb[2*BURSTLEN-1-i] = b;
         s = lfsrStep(s);
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      start = 1'b0;
      outReady = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Pulses start, then logs one sample per cycle (cycle k follows start edge N+k-1) until done.
   task automatic runCapture(input int maxCycles, input int readyLowFrom, input int readyLowLen,
                             input int strayAt);
      obsACycle = 0;
      obsBCycle = 0;
      obsDoneCycle = 0;
      obsAData = '0;
      obsBData = '0;
      obsStraySeq = '0;
      for (int i = 0; i < LOGLEN; i++) begin
         loadLog[i] = 1'b0;
         runLog[i]  = 1'b0;
         busyLog[i] = 1'b0;
         dataLog[i] = '0;
      end
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 1; k <= maxCycles && k < LOGLEN; k++) begin
         @(negedge clock);
         loadLog[k] = load_o;
         runLog[k]  = run_o;
         busyLog[k] = busy;
         dataLog[k] = outBus.out_data;
         if (outBus.out_valid && !outBus.out_sel && obsACycle == 0) begin
            obsACycle = k;
            obsAData  = outBus.out_data;
         end
         if (outBus.out_valid && outBus.out_sel && obsBCycle == 0) begin
            obsBCycle = k;
            obsBData  = outBus.out_data;
         end
         if (k == strayAt) begin
            key_i = ~key_i;
            frame_i = ~frame_i;
            start = 1'b1;
         end
         if (k == strayAt + 1) start = 1'b0;
         if (k == strayAt + 2) obsStraySeq = seq_o;
         outReady = !(k >= readyLowFrom && k < readyLowFrom + readyLowLen);
         if (done) begin
            obsDoneCycle = k;
            break;
         end
      end
      outReady = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] majTable;
      applyReset();
      checkCount++;
      if ({seq_o, load_o, run_o, busy, done} !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_ctrl: got seq=%h load=%b run=%b busy=%b done=%b required all 0",
                  seq_o, load_o, run_o, busy, done);
      end
      checkCount++;
      if ({outBus.out_valid, outBus.out_sel, outBus.out_data} !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_out: got valid=%b sel=%b data=%h required all 0",
                  outBus.out_valid, outBus.out_sel, outBus.out_data);
      end
      majTable = 8'hE8;
      for (int i = 0; i < 8; i++) begin
         {sync1, sync2, sync3} = 3'(i);
         #1;
         checkCount++;
         if (majority_o !== majTable[i]) begin
            errorCount++;
            $display("[TB] FAIL majority_%0d: got %b required %b", i, majority_o, majTable[i]);
         end
      end
   endtask

   task automatic test_basic_run();
      logic [BURSTLEN-1:0] expA, expB;
      int loadCnt, loadFirst, loadLast, runFirst, warmRun, runTotal;
      applyReset();
      patMode = 1'b0;
      key_i = '0;
      frame_i = '0;
      modelWords(16'hACE1, expA, expB);
      runCapture(600, 0, 0, -10);
      loadCnt = 0; loadFirst = 0; loadLast = 0; runFirst = 0; warmRun = 0; runTotal = 0;
      for (int k = 1; k < LOGLEN; k++) begin
         if (loadLog[k]) begin
            loadCnt++;
            if (loadFirst == 0) loadFirst = k;
            loadLast = k;
         end
         if (runLog[k]) begin
            runTotal++;
            if (runFirst == 0) runFirst = k;
            if (k <= 186) warmRun++;
         end
      end
      checkCount++;
      if (loadCnt !== 86 || loadFirst !== 1 || loadLast !== 86) begin
         errorCount++;
         $display("[TB] FAIL load_window: got count=%0d first=%0d last=%0d required 86/1/86",
                  loadCnt, loadFirst, loadLast);
      end
      checkCount++;
      if (runFirst !== 87 || warmRun !== 100) begin
         errorCount++;
         $display("[TB] FAIL warmup: got first=%0d warm=%0d required 87/100", runFirst, warmRun);
      end
      checkCount++;
      if (runTotal !== 328) begin
         errorCount++;
         $display("[TB] FAIL run_total: got %0d required 328", runTotal);
      end
      checkCount++;
      if (obsACycle !== 301 || obsAData !== expA) begin
         errorCount++;
         $display("[TB] FAIL word_a_basic: got cycle=%0d data=%h required 301 %h", obsACycle, obsAData, expA);
      end
      checkCount++;
      if (obsBCycle !== 415 || obsBData !== expB) begin
         errorCount++;
         $display("[TB] FAIL word_b_basic: got cycle=%0d data=%h required 415 %h", obsBCycle, obsBData, expB);
      end
      checkCount++;
      if (obsDoneCycle !== 416 || busyLog[416] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL done_basic: got cycle=%0d busy=%b required 416 0", obsDoneCycle, busyLog[416]);
      end
      @(negedge clock);
      checkCount++;
`ifdef KS_FRAME_AUTOINC_EN
      if (load_o !== 1'b1 || seq_o !== {22'h000001, 64'h0}) begin
         errorCount++;
         $display("[TB] FAIL autoinc_restart: got load=%b seq=%h required 1 %h", load_o, seq_o, {22'h000001, 64'h0});
      end
`else
      if (load_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL after_done_idle: got load=%b busy=%b done=%b required 0 0 0", load_o, busy, done);
      end
`endif
   endtask

   task automatic test_stall();
      logic [BURSTLEN-1:0] expA, expB;
      int runTotal;
      applyReset();
      patMode = 1'b0;
      key_i = 64'h1223456789ABCDEF;
      frame_i = 22'h000134;
      modelWords(16'hCDEF ^ 16'hACE1, expA, expB);
      runCapture(700, 301, 130, -10);
      runTotal = 0;
      for (int k = 1; k < LOGLEN; k++) if (runLog[k]) runTotal++;
      checkCount++;
      if (obsACycle !== 301 || obsAData !== expA) begin
         errorCount++;
         $display("[TB] FAIL word_a_stall: got cycle=%0d data=%h required 301 %h", obsACycle, obsAData, expA);
      end
      checkCount++;
      if (runLog[400] !== 1'b1 || runLog[420] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL stall_run: got run@400=%b run@420=%b required 1 0", runLog[400], runLog[420]);
      end
      checkCount++;
      if (dataLog[430] !== expA) begin
         errorCount++;
         $display("[TB] FAIL hold_stable: got %h required %h", dataLog[430], expA);
      end
      checkCount++;
      if (obsBCycle !== 432 || obsBData !== expB || runTotal !== 328) begin
         errorCount++;
         $display("[TB] FAIL word_b_stall: got cycle=%0d runs=%0d data=%h required 432 328 %h",
                  obsBCycle, runTotal, obsBData, expB);
      end
      checkCount++;
      if (obsDoneCycle !== 433) begin
         errorCount++;
         $display("[TB] FAIL done_stall: got %0d required 433", obsDoneCycle);
      end
   endtask

   task automatic test_reset_mid();
      logic [BURSTLEN-1:0] expA, expB;
      applyReset();
      patMode = 1'b0;
      key_i = 64'h1223456789ABCDEF;
      frame_i = 22'h000134;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (197) @(negedge clock);
      checkCount++;
      if (run_o !== 1'b1 || load_o !== 1'b0 || busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL in_gen_a: got run=%b load=%b busy=%b required 1 0 1", run_o, load_o, busy);
      end
      #2 reset = 1'b1;
      #1;
      checkCount++;
      if ({seq_o, load_o, run_o, busy, done, outBus.out_valid, outBus.out_sel, outBus.out_data} !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_abort: got seq=%h load=%b run=%b busy=%b valid=%b required all 0",
                  seq_o, load_o, run_o, busy, outBus.out_valid);
      end
      @(negedge clock);
      reset = 1'b0;
      key_i = 64'hFEDCBA9876543210;
      frame_i = 22'h02AAAA;
      modelWords(16'h3210 ^ 16'hACE1, expA, expB);
      runCapture(600, 0, 0, -10);
      checkCount++;
      if (obsAData !== expA || obsBData !== expB || obsDoneCycle !== 416) begin
         errorCount++;
         $display("[TB] FAIL restart_words: got A=%h B=%h done=%0d required A=%h B=%h 416",
                  obsAData, obsBData, obsDoneCycle, expA, expB);
      end
   endtask

   task automatic test_start_in_warm();
      logic [KEYLEN-1:0]      keySave;
      logic [FRAMENUMLEN-1:0] frameSave;
      applyReset();
      patMode = 1'b1;
      key_i = 64'h0F1E2D3C4B5A6978;
      frame_i = 22'h3FFFFF;
      keySave = key_i;
      frameSave = frame_i;
      runCapture(600, 0, 0, 120);
      checkCount++;
      if (obsStraySeq !== {frameSave, keySave}) begin
         errorCount++;
         $display("[TB] FAIL stray_start_seq: got %h required %h", obsStraySeq, {frameSave, keySave});
      end
      checkCount++;
      if (obsACycle !== 301 || obsAData !== {BURSTLEN{1'b1}} || obsBData !== {BURSTLEN{1'b1}}) begin
         errorCount++;
         $display("[TB] FAIL stray_start_words: got cycle=%0d A=%h B=%h required 301 all ones",
                  obsACycle, obsAData, obsBData);
      end
      @(negedge clock);
      checkCount++;
`ifdef KS_FRAME_AUTOINC_EN
      if (load_o !== 1'b1 || seq_o !== {22'h000000, keySave}) begin
         errorCount++;
         $display("[TB] FAIL frame_wrap: got load=%b seq=%h required 1 %h", load_o, seq_o, {22'h000000, keySave});
      end
`else
      if (busy !== 1'b0 || seq_o !== {frameSave, keySave}) begin
         errorCount++;
         $display("[TB] FAIL frame_hold: got busy=%b seq=%h required 0 %h", busy, seq_o, {frameSave, keySave});
      end
`endif
      patMode = 1'b0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_run();
      test_stall();
      test_reset_mid();
      test_start_in_warm();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
